// File: rtl/prbs5_pkg.sv
// Shared types and constants for the PRBS5 (x^5+x^2+1) sequence checker.
package prbs5_pkg;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_e;

   typedef enum logic {
      SHIFT_RX   = 1'b0,
      SHIFT_PRED = 1'b1
   } shift_mode_e;

   localparam int TAP_A       = 2;
   localparam int TAP_B       = 4;
   localparam int PRBS_LEN    = 5;
   localparam int PRBS_PERIOD = 31;

   // s(n) = s(n-3) ^ s(n-5) with hist[0] holding s(n-1)
   function automatic logic prbs_predict(input logic [PRBS_LEN-1:0] hist);
      return hist[TAP_A] ^ hist[TAP_B];
   endfunction

endpackage

// File: rtl/prbs5_checker_if.sv
// Serial input / status bundle of the PRBS5 checker.
// PRBS5_CHK_CLR_EN adds the err_clr request line.
interface prbs5_checker_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_bit;
   logic             locked;
   logic             err_pulse;
   logic [CNT_W-1:0] err_cnt;
`ifdef PRBS5_CHK_CLR_EN
   logic             err_clr;

   modport master (
      output in_valid, in_bit, err_clr,
      input  locked, err_pulse, err_cnt
   );

   modport slave (
      input  in_valid, in_bit, err_clr,
      output locked, err_pulse, err_cnt
   );
`else
   modport master (
      output in_valid, in_bit,
      input  locked, err_pulse, err_cnt
   );

   modport slave (
      input  in_valid, in_bit,
      output locked, err_pulse, err_cnt
   );
`endif
endinterface

// File: rtl/prbs5_predict.sv
// History shift register and next-bit predictor; mode chooses whether the
// received bit or the replica's own prediction is shifted in.
module prbs5_predict
   import prbs5_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                advance,
   input  shift_mode_e         mode,
   input  logic                in_bit,
   output logic [PRBS_LEN-1:0] hist,
   output logic                pred
);

   logic [PRBS_LEN-1:0] hist_r;
   logic                pred_s;
   logic                shift_bit_s;

   // Prediction and selection of the bit entering the history
   always_comb begin
      pred_s      = prbs_predict(hist_r);
      shift_bit_s = in_bit;
      if (mode == SHIFT_PRED) begin
         shift_bit_s = pred_s;
      end else begin
         shift_bit_s = in_bit;
      end
   end

   // History register, newest bit at index 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_r <= '0;
      end else if (advance) begin
         hist_r <= {hist_r[PRBS_LEN-2:0], shift_bit_s};
      end else begin
         hist_r <= hist_r;
      end
   end

   assign hist = hist_r;
   assign pred = pred_s;

endmodule

// File: rtl/prbs5_checker.sv
// PRBS5 checker: HUNT/SYNC/LOCKED tracking FSM, error pulse and saturating counter.
// Define PRBS5_CHK_CLR_EN to enable the synchronous err_clr counter clear.
module prbs5_checker
   import prbs5_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int LOSS_CNT = 4,
   parameter int CNT_W    = 8
) (
   input logic            clk,
   input logic            rst,
   prbs5_checker_if.slave bus
);

   localparam int FILL_W  = $clog2(PRBS_LEN);
   localparam int MATCH_W = $clog2(PRBS_PERIOD + 1);
   localparam int CONS_W  = 4;

   localparam logic [FILL_W-1:0]  FILL_LAST = FILL_W'(PRBS_LEN - 1);
   localparam logic [MATCH_W-1:0] LOCK_TGT  = MATCH_W'(LOCK_CNT);
   localparam logic [CONS_W-1:0]  LOSS_TGT  = CONS_W'(LOSS_CNT);
   localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

   state_e               state_r, state_s;
   logic [FILL_W-1:0]    fill_r, fill_s;
   logic [MATCH_W-1:0]   match_r, match_s;
   logic [CONS_W-1:0]    cons_r, cons_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s;
   logic                 locked_r, locked_s;
   logic                 pulse_r;
   logic                 err_hit_s;
   logic                 bit_err_s;
   logic                 hist_nz_s;
   logic [PRBS_LEN-1:0]  hist_s;
   logic                 pred_s;
   shift_mode_e          mode_s;

   prbs5_predict u_predict (
      .clk     (clk),
      .rst     (rst),
      .advance (bus.in_valid),
      .mode    (mode_s),
      .in_bit  (bus.in_bit),
      .hist    (hist_s),
      .pred    (pred_s)
   );

   assign bit_err_s = bus.in_bit ^ pred_s;
   assign hist_nz_s = |hist_s;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= HUNT;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and tracking counters; only valid bits advance anything
   always_comb begin
      state_s = state_r;
      fill_s  = fill_r;
      match_s = match_r;
      cons_s  = cons_r;
      if (bus.in_valid) begin
         case (state_r)
            HUNT: begin
               if (fill_r == FILL_LAST) begin
                  state_s = SYNC;
                  fill_s  = '0;
                  match_s = '0;
               end else begin
                  fill_s  = fill_r + FILL_W'(1'b1);
               end
            end
            SYNC: begin
               // an all-zero history is never a match, so a stuck-at-0 line cannot lock
               if (!bit_err_s && hist_nz_s) begin
                  match_s = match_r + MATCH_W'(1'b1);
                  if (match_s == LOCK_TGT) begin
                     state_s = LOCKED;
                     cons_s  = '0;
                  end else begin
                     state_s = SYNC;
                  end
               end else begin
                  match_s = '0;
               end
            end
            LOCKED: begin
               if (bit_err_s) begin
                  cons_s = cons_r + CONS_W'(1'b1);
                  if (cons_s == LOSS_TGT) begin
                     state_s = HUNT;
                     fill_s  = '0;
                     cons_s  = '0;
                  end else begin
                     state_s = LOCKED;
                  end
               end else begin
                  cons_s = '0;
               end
            end
            default: begin
               state_s = HUNT;
               fill_s  = '0;
               match_s = '0;
               cons_s  = '0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // Replica mode, error detection and next status values
   always_comb begin
      mode_s    = (state_r == LOCKED) ? SHIFT_PRED : SHIFT_RX;
      err_hit_s = bus.in_valid && (state_r == LOCKED) && bit_err_s;
      locked_s  = (state_s == LOCKED);
      cnt_s     = cnt_r;
`ifdef PRBS5_CHK_CLR_EN
      if (bus.err_clr) begin
         cnt_s = '0;
      end else if (err_hit_s && (cnt_r != CNT_MAX)) begin
         cnt_s = cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_s = cnt_r;
      end
`else
      if (err_hit_s && (cnt_r != CNT_MAX)) begin
         cnt_s = cnt_r + CNT_W'(1'b1);
      end else begin
         cnt_s = cnt_r;
      end
`endif
   end

   // Counter and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fill_r   <= '0;
         match_r  <= '0;
         cons_r   <= '0;
         cnt_r    <= '0;
         locked_r <= 1'b0;
         pulse_r  <= 1'b0;
      end else begin
         fill_r   <= fill_s;
         match_r  <= match_s;
         cons_r   <= cons_s;
         cnt_r    <= cnt_s;
         locked_r <= locked_s;
         pulse_r  <= err_hit_s;
      end
   end

   assign bus.locked    = locked_r;
   assign bus.err_pulse = pulse_r;
   assign bus.err_cnt   = cnt_r;

endmodule

// File: tb/tb_prbs5_checker.sv
// Bench for prbs5_checker: table-driven scenarios plus hand sequences, with a
// per-cycle scoreboard against a behavioural model (CNT_W 8 and CNT_W 3 instances).
module tb_prbs5_checker;

   localparam int LOCK = 8;
   localparam int LOSS = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_valid = 1'b0;
   logic tb_bit = 1'b0;
   logic tb_clr = 1'b0;

   always #5 clk = ~clk;

   prbs5_checker_if #(.CNT_W(8)) bus_a ();
   prbs5_checker_if #(.CNT_W(3)) bus_b ();

   assign bus_a.in_valid = tb_valid;
   assign bus_a.in_bit   = tb_bit;
   assign bus_b.in_valid = tb_valid;
   assign bus_b.in_bit   = tb_bit;
`ifdef PRBS5_CHK_CLR_EN
   assign bus_a.err_clr  = tb_clr;
   assign bus_b.err_clr  = tb_clr;
`endif

   prbs5_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(8)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave));
   prbs5_checker #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS), .CNT_W(3)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave));

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      bit la; bit pa; int ca;
      bit lb; bit pb; int cb;
   } exp_t;
   exp_t sb_q[$];

   // behavioural model, one slot per DUT (0: CNT_W 8, 1: CNT_W 3)
   int       m_state[2];
   int       m_fill[2];
   int       m_match[2];
   int       m_cons[2];
   int       m_cnt[2];
   int       m_max[2] = '{255, 7};
   bit [4:0] m_hist[2];
   bit       m_pulse[2];

   logic [4:0] gen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = 0; m_fill[k] = 0; m_match[k] = 0; m_cons[k] = 0;
         m_cnt[k] = 0; m_hist[k] = 5'd0; m_pulse[k] = 1'b0;
      end
   endfunction

   function automatic void model_step(input bit v, input bit b);
      bit p;
      for (int k = 0; k < 2; k++) begin
         p = m_hist[k][2] ^ m_hist[k][4];
         m_pulse[k] = 1'b0;
         if (v) begin
            if (m_state[k] == 0) begin
               m_hist[k] = {m_hist[k][3:0], b};
               m_fill[k]++;
               if (m_fill[k] == 5) begin m_state[k] = 1; m_match[k] = 0; end
            end else if (m_state[k] == 1) begin
               if (b == p && m_hist[k] != 5'd0) m_match[k]++;
               else m_match[k] = 0;
               m_hist[k] = {m_hist[k][3:0], b};
               if (m_match[k] == LOCK) begin m_state[k] = 2; m_cons[k] = 0; end
            end else begin
               m_hist[k] = {m_hist[k][3:0], p};
               if (b != p) begin
                  m_pulse[k] = 1'b1;
                  if (m_cnt[k] < m_max[k]) m_cnt[k]++;
                  m_cons[k]++;
                  if (m_cons[k] == LOSS) begin m_state[k] = 0; m_fill[k] = 0; m_cons[k] = 0; end
               end else begin
                  m_cons[k] = 0;
               end
            end
         end
         if (tb_clr) m_cnt[k] = 0;
      end
   endfunction

   function automatic bit gen_next();
      bit o;
      o   = gen[4];
      gen = {gen[3:0], gen[4] ^ gen[2]};
      return o;
   endfunction

   // Drive one cycle, predict, then compare after the edge
   task automatic step(input bit v, input bit b, input bit clr);
      exp_t e;
      @(negedge clk);
      tb_valid = v; tb_bit = b; tb_clr = clr;
      model_step(v, b);
      e.la = (m_state[0] == 2); e.pa = m_pulse[0]; e.ca = m_cnt[0];
      e.lb = (m_state[1] == 2); e.pb = m_pulse[1]; e.cb = m_cnt[1];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check("locked_a", bus_a.locked, e.la);
         check("pulse_a", bus_a.err_pulse, e.pa);
         check("cnt_a", bus_a.err_cnt, e.ca);
         check("locked_b", bus_b.locked, e.lb);
         check("pulse_b", bus_b.err_pulse, e.pb);
         check("cnt_b", bus_b.err_cnt, e.cb);
      end
   endtask

   // Asynchronous reset in mid-cycle; outputs must clear before any clock edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; tb_valid = 1'b0; tb_clr = 1'b0;
      #1;
      check("rst_locked_a", bus_a.locked, 32'd0);
      check("rst_pulse_a", bus_a.err_pulse, 32'd0);
      check("rst_cnt_a", bus_a.err_cnt, 32'd0);
      check("rst_cnt_b", bus_b.err_cnt, 32'd0);
      model_reset();
      gen = 5'b00001;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic send_clean(input int n);
      for (int i = 0; i < n; i++) step(1'b1, gen_next(), 1'b0);
   endtask

   typedef struct {
      string name;
      int    mode;        // 0 clean, 1 stuck-at-0, 2 gapped
      int    n_valid;
      int    flip_at;
      int    flip_every;
      int    flip_num;
      bit    exp_locked;
      int    exp_cnt_a;
      int    exp_cnt_b;
   } vec_t;

   vec_t tbl[10];

   initial begin
      bit b;
      int ofs;
      tbl[0] = '{"clean_12",    0,  12,  0,  1,  0, 1'b0,  0, 0};
      tbl[1] = '{"clean_13",    0,  13,  0,  1,  0, 1'b1,  0, 0};
      tbl[2] = '{"clean_200",   0, 200,  0,  1,  0, 1'b1,  0, 0};
      tbl[3] = '{"single_flip", 0,  80, 40,  1,  1, 1'b1,  1, 1};
      tbl[4] = '{"flip3",       0,  60, 40,  1,  3, 1'b1,  3, 3};
      tbl[5] = '{"loss",        0,  43, 40,  1,  4, 1'b0,  4, 4};
      tbl[6] = '{"relock",      0,  56, 40,  1,  4, 1'b1,  4, 4};
      tbl[7] = '{"stuck0",      1, 100,  0,  1,  0, 1'b0,  0, 0};
      tbl[8] = '{"gapped_13",   2,  13,  0,  1,  0, 1'b1,  0, 0};
      tbl[9] = '{"saturate",    0, 140, 40, 10, 10, 1'b1, 10, 7};

      model_reset();
      gen = 5'b00001;
      repeat (2) @(posedge clk);

      for (int r = 0; r < 10; r++) begin
         do_reset();
         for (int i = 1; i <= tbl[r].n_valid; i++) begin
            if (tbl[r].mode == 2) begin
               repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            end
            b = gen_next();
            if (tbl[r].mode == 1) b = 1'b0;
            ofs = i - tbl[r].flip_at;
            if (tbl[r].flip_num > 0 && ofs >= 0 && (ofs % tbl[r].flip_every) == 0 &&
                (ofs / tbl[r].flip_every) < tbl[r].flip_num) b = ~b;
            step(1'b1, b, 1'b0);
         end
         check({tbl[r].name, "_locked_a"}, bus_a.locked, tbl[r].exp_locked);
         check({tbl[r].name, "_locked_b"}, bus_b.locked, tbl[r].exp_locked);
         check({tbl[r].name, "_cnt_a"}, bus_a.err_cnt, tbl[r].exp_cnt_a);
         check({tbl[r].name, "_cnt_b"}, bus_b.err_cnt, tbl[r].exp_cnt_b);
      end

      // single flip: pulse lasts one cycle, dropping on a gap cycle
      do_reset();
      send_clean(20);
      step(1'b1, ~gen_next(), 1'b0);
      check("flip_pulse_hi", bus_a.err_pulse, 32'd1);
      check("flip_cnt", bus_a.err_cnt, 32'd1);
      step(1'b0, 1'b1, 1'b0);
      check("flip_pulse_gap", bus_a.err_pulse, 32'd0);
      check("flip_locked", bus_a.locked, 32'd1);

      // back-to-back errors keep the pulse high, then reset mid-lock
      step(1'b1, ~gen_next(), 1'b0);
      check("b2b_pulse_1", bus_a.err_pulse, 32'd1);
      step(1'b1, ~gen_next(), 1'b0);
      check("b2b_pulse_2", bus_a.err_pulse, 32'd1);
      check("b2b_cnt", bus_a.err_cnt, 32'd3);
      check("b2b_locked", bus_a.locked, 32'd1);
      do_reset();
      send_clean(13);
      check("after_rst_relock", bus_a.locked, 32'd1);

`ifdef PRBS5_CHK_CLR_EN
      // clear coincident with an error wins over the increment
      do_reset();
      send_clean(20);
      step(1'b1, ~gen_next(), 1'b1);
      check("clr_err_cnt", bus_a.err_cnt, 32'd0);
      check("clr_err_pulse", bus_a.err_pulse, 32'd1);
      step(1'b1, ~gen_next(), 1'b0);
      check("clr_then_err", bus_a.err_cnt, 32'd1);
      step(1'b0, 1'b0, 1'b1);
      check("clr_on_gap", bus_a.err_cnt, 32'd0);
      step(1'b1, gen_next(), 1'b0);
`endif

      @(negedge clk);
      tb_valid = 1'b0;
      tb_clr   = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/prbs5_checker.md
# prbs5_checker

Serial pseudo-random sequence checker placed directly downstream of the 5-bit LFSR generator. It consumes the generator's serial output bit, synchronises a local replica of the x^5+x^2+1 sequence (period 31), and then free-runs that replica to flag and count bit errors. It provides lock status and a saturating error counter to the test/status logic.

## Interface
- `LOCK_CNT`, default 8: consecutive correct predictions needed in SYNC to declare lock (1..31).
- `LOSS_CNT`, default 4: consecutive errors in LOCKED that drop lock (1..15).
- `CNT_W`, default 8: width of the error counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_bit` is sampled this cycle; no back-pressure.
- `in_bit`  in  1  received sequence bit (generator `q[4]`).
- `locked`  out  1  registered; high while in LOCKED.
- `err_pulse`  out  1  registered; one-cycle pulse per mismatched bit in LOCKED.
- `err_cnt`  out  CNT_W  registered saturating count of errors seen in LOCKED.
- `err_clr`  in  1  synchronous counter clear (present only with `PRBS5_CHK_CLR_EN`).

## Operation
- The history register `h[4:0]` holds the five previous bits, with `h[0]` the most recent. The predicted bit is `p = h[2] ^ h[4]`, from the recurrence s(n) = s(n-3) ^ s(n-5).
- Nothing changes on cycles where `in_valid` is 0, except that `err_pulse` returns to 0.
- **HUNT** (reset state):
  - Each valid bit shifts into `h`, and a fill counter counts 0..4.
  - On the 5th valid bit, go to SYNC with the match counter at 0.
- **SYNC**:
  - Each valid bit shifts into `h` as the received bit.
  - If `in_bit == p` and `h != 0`, the match counter increments.
  - Otherwise the match counter resets to 0. An all-zero history never counts as a match, which prevents lock on a stuck-at-0 line.
  - When the match counter reaches `LOCK_CNT`, go to LOCKED.
- **LOCKED**:
  - `h` shifts in `p`, not `in_bit`. The replica free-runs, so one flipped bit produces exactly one error.
  - A mismatch sets `err_pulse`, increments `err_cnt` (saturating at 2^CNT_W-1) and increments the consecutive-error counter.
  - A match clears the consecutive-error counter.
  - When the consecutive-error counter reaches `LOSS_CNT`, go to HUNT with the fill counter at 0. `err_cnt` is kept.
- Errors are counted only in LOCKED. Mismatches in HUNT or SYNC never touch `err_pulse` or `err_cnt`.

## Timing
- Reset values: state HUNT, `h` = 0, all internal counters 0, `locked` = 0, `err_pulse` = 0, `err_cnt` = 0.
- Reset takes effect immediately, including mid-lock. The first valid bit after deassertion is fill bit 1.
- Lock latency: `locked` rises on the clock edge that consumes valid bit number 5+`LOCK_CNT` (clean stream, non-zero history), and is visible in the following cycle.
- `err_pulse` is high for exactly the cycle after the edge that consumed the erroneous bit. On back-to-back errors it stays high continuously.
- `err_cnt` updates on the same edge as `err_pulse`.
- Loss of lock: `locked` falls on the edge that consumes the `LOSS_CNT`-th consecutive error; `err_pulse` is also high for that bit.
- Gaps in `in_valid` do not affect correctness; only valid bits advance state.

## Configuration
- `PRBS5_CHK_CLR_EN` defined: port `err_clr` exists. When it is high on an edge, `err_cnt` becomes 0 on that edge.
  - If an error occurs on the same edge, clear wins and `err_cnt` = 0; `err_pulse` still fires.
- Not defined: there is no `err_clr` port, and `err_cnt` is cleared only by `rst`.

## Structure
- Shared package `prbs5_pkg`:
  - state enum `{HUNT, SYNC, LOCKED}`
  - tap constants `TAP_A = 2`, `TAP_B = 4`
  - `PRBS_LEN = 5`, `PRBS_PERIOD = 31`
- Sub-module `prbs5_predict`: history shift register plus predictor. It has a mode input that selects whether the received or the predicted bit is shifted in.
- The FSM and counters live in `prbs5_checker`.

## Test plan
- **Clean lock:** generator seeded `5'b00001`, `in_valid` = 1 continuously → `locked` = 1 after 13 valid bits; `err_cnt` stays 0 over 200 bits.
- **Single flip:** once locked, invert one bit → `err_pulse` high for exactly one cycle, `err_cnt` = 1, `locked` stays 1.
- **Loss of lock:** once locked, force 4 consecutive inverted bits → `err_cnt` = 4, `locked` = 0 after the 4th. The clean stream that follows relocks after 13 more valid bits.
- **Stuck-at-0:** `in_bit` = 0 for 100 valid bits → `locked` stays 0, `err_cnt` stays 0.
- **Gapped input plus reset:** random `in_valid` gaps on a clean stream → lock still occurs after 13 valid bits. `rst` asserted mid-lock → all outputs 0 immediately.
- **Saturation and clear:** `CNT_W` = 3, 10 isolated errors → `err_cnt` saturates at 7. With `PRBS5_CHK_CLR_EN`, `err_clr` coincident with an error → `err_cnt` = 0 and `err_pulse` = 1.
